dff_seq_ctrl: RTL and testbench

- Self-test sequencer for the lab's single D flip-flop block. That flip-flop has an async active-low preset (pre), an async active-low clear (clr), a clock (clk) and data (d), and outputs q and qb.
- This block drives the flip-flop's pre/clr/clock/d from a fixed 8-step vector program, samples q/qb once per step and accumulates pass/fail results.
- It sits beside the flip-flop on the board top and replaces hand-toggled switches. One start pulse runs the whole program.

---
 rtl/dff_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dff_seq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_seq_ctrl.sv
// Self-test sequencer for a single async-preset/clear D flip-flop: runs an 8-step vector program.
// Optional build macro DFF_SEQ_SYNC_EN adds two-flop synchronizers on ff_q/ff_qb (requires HALF >= 3).
module dff_seq_ctrl #(
  parameter int unsigned HALF  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       ff_q,
  input  logic       ff_qb,
  output logic       ff_pre_n,
  output logic       ff_clr_n,
  output logic       ff_clk,
  output logic       ff_d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] err_mask,
  output logic [2:0] step
);

  // Vector program, bit i belongs to step i
  localparam logic [7:0] PRE_N_V = 8'hBD;
  localparam logic [7:0] CLR_N_V = 8'hBE;
  localparam logic [7:0] D_V     = 8'hC9;
  localparam logic [7:0] EDGE_V  = 8'hAC;
  localparam logic [7:0] EXP_Q_V = 8'h9A;
  localparam logic [7:0] CHK_V   = 8'hBF;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       step_q, step_d;
  logic [3:0]       err_cnt_q, err_cnt_d;
  logic [7:0]       err_mask_q, err_mask_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pre_n_q, pre_n_d;
  logic             clr_n_q, clr_n_d;
  logic             fclk_q, fclk_d;
  logic             fd_q, fd_d;
  logic             q_cmp, qb_cmp, fail_c;

`ifdef DFF_SEQ_SYNC_EN
  logic q_meta_q, q_meta_d, q_sync_q, q_sync_d;
  logic qb_meta_q, qb_meta_d, qb_sync_q, qb_sync_d;

  always_comb begin
    q_meta_d  = ff_q;
    q_sync_d  = q_meta_q;
    qb_meta_d = ff_qb;
    qb_sync_d = qb_meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_meta_q  <= 1'b0;
      q_sync_q  <= 1'b0;
      qb_meta_q <= 1'b0;
      qb_sync_q <= 1'b0;
    end else begin
      q_meta_q  <= q_meta_d;
      q_sync_q  <= q_sync_d;
      qb_meta_q <= qb_meta_d;
      qb_sync_q <= qb_sync_d;
    end
  end

  assign q_cmp  = q_sync_q;
  assign qb_cmp = qb_sync_q;
`else
  assign q_cmp  = ff_q;
  assign qb_cmp = ff_qb;
`endif

  // A checked step fails on a wrong q or on qb not being the complement of q
  assign fail_c = CHK_V[step_q] & ((q_cmp != EXP_Q_V[step_q]) | (qb_cmp == q_cmp));

  // Next state, counters and results; registered outputs follow the next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    err_cnt_d  = err_cnt_q;
    err_mask_d = err_mask_q;
    pass_d     = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          err_cnt_d  = 4'd0;
          err_mask_d = 8'd0;
          pass_d     = 1'b0;
          step_d     = 3'd0;
          cnt_d      = '0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP, S_HIGH: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == S_SETUP) ? S_HIGH : S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (fail_c) begin
            err_mask_d[step_q] = 1'b1;
            err_cnt_d          = err_cnt_q + 4'd1;
          end
          if (step_q == 3'd7) begin
            pass_d  = (err_mask_d == 8'd0);
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_SETUP;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_CHECK);
    done_d  = (state_d == S_DONE);
    pre_n_d = 1'b1;
    clr_n_d = 1'b1;
    fclk_d  = 1'b0;
    fd_d    = 1'b0;
    if (busy_d) begin
      pre_n_d = PRE_N_V[step_d];
      clr_n_d = CLR_N_V[step_d];
      fd_d    = D_V[step_d];
      fclk_d  = (state_d != S_SETUP) && EDGE_V[step_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      step_q     <= 3'd0;
      err_cnt_q  <= 4'd0;
      err_mask_q <= 8'd0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pre_n_q    <= 1'b1;
      clr_n_q    <= 1'b1;
      fclk_q     <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      err_cnt_q  <= err_cnt_d;
      err_mask_q <= err_mask_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pre_n_q    <= pre_n_d;
      clr_n_q    <= clr_n_d;
      fclk_q     <= fclk_d;
      fd_q       <= fd_d;
    end
  end

  assign ff_pre_n = pre_n_q;
  assign ff_clr_n = clr_n_q;
  assign ff_clk   = fclk_q;
  assign ff_d     = fd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign err_mask = err_mask_q;
  assign step     = step_q;

endmodule

// File: tb/tb_dff_seq_ctrl.sv
// Bench for dff_seq_ctrl: HALF=4 and HALF=2 instances, each driving a behavioural flip-flop with fault modes.
module tb_dff_seq_ctrl;
  localparam int unsigned HA = 4;
  localparam int unsigned HB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  int   mode_a = 0, mode_b = 0;  // 0 good, 1 stuck-at-0 (q=0,qb=1), 2 qb tied to q

  logic a_q, a_qb, a_pre_n, a_clr_n, a_clk, a_d, a_busy, a_done, a_pass;
  logic [3:0] a_err_cnt;
  logic [7:0] a_err_mask;
  logic [2:0] a_step;
  logic b_q, b_qb, b_pre_n, b_clr_n, b_clk, b_d, b_busy, b_done, b_pass;
  logic [3:0] b_err_cnt;
  logic [7:0] b_err_mask;
  logic [2:0] b_step;

  dff_seq_ctrl #(.HALF(HA), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .ff_q(a_q), .ff_qb(a_qb),
    .ff_pre_n(a_pre_n), .ff_clr_n(a_clr_n), .ff_clk(a_clk), .ff_d(a_d), .busy(a_busy),
    .done(a_done), .pass(a_pass), .err_cnt(a_err_cnt), .err_mask(a_err_mask), .step(a_step));

  dff_seq_ctrl #(.HALF(HB), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .ff_q(b_q), .ff_qb(b_qb),
    .ff_pre_n(b_pre_n), .ff_clr_n(b_clr_n), .ff_clk(b_clk), .ff_d(b_d), .busy(b_busy),
    .done(b_done), .pass(b_pass), .err_cnt(b_err_cnt), .err_mask(b_err_mask), .step(b_step));

  // Flip-flops under test: clear has priority over preset
  logic a_ff = 1'b0, b_ff = 1'b0;
  always @(posedge a_clk or negedge a_pre_n or negedge a_clr_n)
    if (!a_clr_n) a_ff <= 1'b0; else if (!a_pre_n) a_ff <= 1'b1; else a_ff <= a_d;
  always @(posedge b_clk or negedge b_pre_n or negedge b_clr_n)
    if (!b_clr_n) b_ff <= 1'b0; else if (!b_pre_n) b_ff <= 1'b1; else b_ff <= b_d;

  assign a_q  = (mode_a == 1) ? 1'b0 : a_ff;
  assign a_qb = (mode_a == 1) ? 1'b1 : (mode_a == 2) ? a_ff : ~a_ff;
  assign b_q  = (mode_b == 1) ? 1'b0 : b_ff;
  assign b_qb = (mode_b == 1) ? 1'b1 : (mode_b == 2) ? b_ff : ~b_ff;

  // Program table as (pre_n, clr_n, d, edge, expected q); -1 marks the unchecked step
  int t_pre [8] = '{1, 0, 1, 1, 1, 1, 0, 1};
  int t_clr [8] = '{0, 1, 1, 1, 1, 1, 0, 1};
  int t_d   [8] = '{1, 0, 0, 1, 0, 0, 1, 1};
  int t_edge[8] = '{0, 0, 1, 1, 0, 1, 0, 1};
  int t_exp [8] = '{0, 1, 0, 1, 1, 0, -1, 1};
  string onames[10] = '{"busy", "done", "pass", "err_cnt", "err_mask", "step",
                        "pre_n", "clr_n", "ff_clk", "ff_d"};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int outv(input int k, input int idx);
    logic [7:0] v;
    case (idx)
      0: v = 8'(k == 0 ? a_busy : b_busy);
      1: v = 8'(k == 0 ? a_done : b_done);
      2: v = 8'(k == 0 ? a_pass : b_pass);
      3: v = 8'(k == 0 ? a_err_cnt : b_err_cnt);
      4: v = (k == 0) ? a_err_mask : b_err_mask;
      5: v = 8'(k == 0 ? a_step : b_step);
      6: v = 8'(k == 0 ? a_pre_n : b_pre_n);
      7: v = 8'(k == 0 ? a_clr_n : b_clr_n);
      8: v = 8'(k == 0 ? a_clk : b_clk);
      default: v = 8'(k == 0 ? a_d : b_d);
    endcase
    return int'(v);
  endfunction

  function automatic int half_of(input int k);
    return (k == 0) ? int'(HA) : int'(HB);
  endfunction

  // Whether a step is recorded as failed, from the fault mode alone
  function automatic bit step_fails(input int mode, input int s);
    if (t_exp[s] < 0) return 1'b0;
    if (mode == 1) return t_exp[s] != 0;
    return mode == 2;
  endfunction

  // Model: a run is a cycle count t since busy rose; step=t/P, phase=t%P with P=2*HALF+1
  bit         m_valid = 1'b0;
  bit         m_run [2];
  bit         m_done[2];
  bit         m_pass[2];
  int         m_t   [2];
  int         m_cnt [2];
  int         m_step[2];
  logic [7:0] m_mask[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit st, ab;
      int p, s, nc;
      logic [7:0] nm;
      st = (k == 0) ? start_a : start_b;
      ab = (k == 0) ? abort_a : abort_b;
      p  = 2 * half_of(k) + 1;
      s  = m_t[k] / p;
      nm = m_mask[k];
      nc = m_cnt[k];
      if (rst) begin
        m_valid   <= 1'b1;
        m_run[k]  <= 1'b0;
        m_done[k] <= 1'b0;
        m_pass[k] <= 1'b0;
        m_t[k]    <= 0;
        m_cnt[k]  <= 0;
        m_step[k] <= 0;
        m_mask[k] <= 8'd0;
      end else if (m_run[k]) begin
        if (ab) begin
          m_run[k]  <= 1'b0;
          m_pass[k] <= 1'b0;
          m_step[k] <= s;
        end else begin
          if (m_t[k] % p == p - 1) begin
            if (step_fails((k == 0) ? mode_a : mode_b, s)) begin
              nm[s] = 1'b1;
              nc++;
            end
            if (s == 7) begin
              m_run[k]  <= 1'b0;
              m_done[k] <= 1'b1;
              m_pass[k] <= (nm == 8'd0);
              m_step[k] <= 7;
            end
          end
          m_mask[k] <= nm;
          m_cnt[k]  <= nc;
          m_t[k]    <= m_t[k] + 1;
        end
      end else if (m_done[k]) begin
        m_done[k] <= 1'b0;
      end else if (st && !ab) begin
        m_run[k]  <= 1'b1;
        m_t[k]    <= 0;
        m_mask[k] <= 8'd0;
        m_cnt[k]  <= 0;
        m_pass[k] <= 1'b0;
        m_step[k] <= 0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        int e[10];
        int p, s, ph;
        p  = 2 * half_of(k) + 1;
        s  = m_t[k] / p;
        ph = m_t[k] % p;
        e[0] = int'(m_run[k]);
        e[1] = int'(m_done[k]);
        e[2] = int'(m_pass[k]);
        e[3] = m_cnt[k];
        e[4] = int'(m_mask[k]);
        e[5] = m_run[k] ? s : m_step[k];
        e[6] = m_run[k] ? t_pre[s] : 1;
        e[7] = m_run[k] ? t_clr[s] : 1;
        e[8] = (m_run[k] && ph >= half_of(k)) ? t_edge[s] : 0;
        e[9] = m_run[k] ? t_d[s] : 0;
        for (int i = 0; i < 10; i++)
          chk($sformatf("%s_%s", (k == 0) ? "a" : "b", onames[i]), outv(k, i), e[i]);
      end
    end
  end

  task automatic pulse(input int k, input bit s, input bit a);
    if (k == 0) begin start_a = s; abort_a = a; end
    else begin start_b = s; abort_b = a; end
  endtask

  // Start a run and wait for done, counting busy cycles; extra start pulses optionally poked in
  task automatic run(input int k, input int mode, input bit poke, output int bc);
    bit got;
    if (k == 0) mode_a = mode; else mode_b = mode;
    pulse(k, 1'b1, 1'b0);
    bc  = 0;
    got = 1'b0;
    for (int i = 1; i <= 200 && !got; i++) begin
      @(negedge clk);
      pulse(k, poke && (i == 5 || i == 40 || i == 72), 1'b0);
      if (outv(k, 0) != 0) bc++;
      if (outv(k, 1) != 0) got = 1'b1;
    end
    pulse(k, 1'b0, 1'b0);
    chk("done_seen", int'(got), 1);
  endtask

  initial begin
    int bc;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++)
      chk({"reset_", onames[i]}, outv(0, i), (i == 6 || i == 7) ? 1 : 0);
    rst = 1'b0;
    @(negedge clk);

    run(0, 0, 1'b1, bc);
    chk("good_busy_len", bc, 72);
    chk("good_pass", outv(0, 2), 1);
    chk("good_mask", outv(0, 4), 8'h00);
    chk("good_cnt", outv(0, 3), 0);
    @(negedge clk);
    chk("good_pass_hold", outv(0, 2), 1);

    run(0, 1, 1'b0, bc);
    chk("stuck0_mask", outv(0, 4), 8'h9A);
    chk("stuck0_cnt", outv(0, 3), 4);
    chk("stuck0_pass", outv(0, 2), 0);
    @(negedge clk);

    run(0, 2, 1'b0, bc);
    chk("qbeq_mask", outv(0, 4), 8'hBF);
    chk("qbeq_cnt", outv(0, 3), 7);
    chk("qbeq_pass", outv(0, 2), 0);
    @(negedge clk);

    // Abort in the second HIGH cycle of step 3
    mode_a = 1;
    pulse(0, 1'b1, 1'b0);
    @(negedge clk);
    pulse(0, 1'b0, 1'b0);
    repeat (32) @(negedge clk);
    chk("pre_abort_step", outv(0, 5), 3);
    chk("pre_abort_clk", outv(0, 8), 1);
    pulse(0, 1'b0, 1'b1);
    @(negedge clk);
    pulse(0, 1'b0, 1'b0);
    chk("abort_busy", outv(0, 0), 0);
    chk("abort_pre_n", outv(0, 6), 1);
    chk("abort_clr_n", outv(0, 7), 1);
    chk("abort_clk", outv(0, 8), 0);
    chk("abort_pass", outv(0, 2), 0);
    chk("abort_mask", outv(0, 4), 8'h02);
    chk("abort_cnt", outv(0, 3), 1);
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_done", outv(0, 1), 0);
    end

    // start and abort together in IDLE: start dropped, partial results untouched
    pulse(0, 1'b1, 1'b1);
    @(negedge clk);
    pulse(0, 1'b0, 1'b0);
    chk("startabort_busy", outv(0, 0), 0);
    chk("startabort_mask", outv(0, 4), 8'h02);
    @(negedge clk);

    // Reset in SETUP of step 5 of a faulty run
    mode_a = 1;
    pulse(0, 1'b1, 1'b0);
    @(negedge clk);
    pulse(0, 1'b0, 1'b0);
    repeat (46) @(negedge clk);
    chk("pre_rst_step", outv(0, 5), 5);
    chk("pre_rst_mask", outv(0, 4), 8'h1A);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++)
      chk({"midrst_", onames[i]}, outv(0, i), (i == 6 || i == 7) ? 1 : 0);
    @(negedge clk);
    run(0, 0, 1'b0, bc);
    chk("postrst_busy_len", bc, 72);
    chk("postrst_pass", outv(0, 2), 1);
    @(negedge clk);

    run(1, 0, 1'b0, bc);
    chk("half2_busy_len", bc, 40);
    chk("half2_pass", outv(1, 2), 1);
    @(negedge clk);
    run(1, 1, 1'b0, bc);
    chk("half2_stuck0_mask", outv(1, 4), 8'h9A);
    chk("half2_stuck0_cnt", outv(1, 3), 4);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
